// File: rtl/mrelbp_interp_pkg.sv
// Shared types and the elaboration-time ring geometry for the MRELBP ring sampler.
package mrelbp_interp_pkg;

  localparam int unsigned NPOINTS  = 8;
  localparam int unsigned COS45_Q8 = 181;

  // fx weights the column neighbour, fy the row neighbour; FRAC is limited to 16.
  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [16:0] fx;
    logic [16:0] fy;
  } point_t;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} ring_state_e;

  function automatic point_t ring_point(input int unsigned k, input int unsigned radius,
                                        input int unsigned frac);
    point_t      p;
    int unsigned d, di, dfs, pos_b, pos_f, neg_b, neg_f;
    d   = radius * COS45_Q8;
    di  = d >> 8;
    dfs = (frac >= 8) ? ((d & 255) << (frac - 8)) : ((d & 255) >> (8 - frac));
    pos_b = radius + di;
    pos_f = dfs;
    // An exact integer offset has no fractional neighbour on the negative side.
    if (dfs == 0) begin
      neg_b = radius - di;
      neg_f = 0;
    end else begin
      neg_b = radius - di - 1;
      neg_f = (1 << frac) - dfs;
    end
    p = '0;
    case (k)
      0: begin p.row = 8'(radius);     p.col = 8'(2 * radius); end
      1: begin p.row = 8'(pos_b); p.fy = 17'(pos_f); p.col = 8'(pos_b); p.fx = 17'(pos_f); end
      2: begin p.row = 8'(2 * radius); p.col = 8'(radius);     end
      3: begin p.row = 8'(pos_b); p.fy = 17'(pos_f); p.col = 8'(neg_b); p.fx = 17'(neg_f); end
      4: begin p.row = 8'(radius);     p.col = 8'd0;           end
      5: begin p.row = 8'(neg_b); p.fy = 17'(neg_f); p.col = 8'(neg_b); p.fx = 17'(neg_f); end
      6: begin p.row = 8'd0;           p.col = 8'(radius);     end
      7: begin p.row = 8'(neg_b); p.fy = 17'(neg_f); p.col = 8'(pos_b); p.fx = 17'(pos_f); end
      default: ;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/interp_lerp_pipe.sv
// Two-stage bilinear datapath with a shared stall enable.
// Define INTERP_ROUND_EN to round the output to an integer pixel instead of truncating.
module interp_lerp_pipe
  import mrelbp_interp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned FRAC  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [WIDTH-1:0]      p00_i,
  input  logic [WIDTH-1:0]      p01_i,
  input  logic [WIDTH-1:0]      p10_i,
  input  logic [WIDTH-1:0]      p11_i,
  input  logic [FRAC:0]         fx_i,
  input  logic [FRAC:0]         fy_i,
  output logic [WIDTH+FRAC-1:0] sample_o
);

  localparam int unsigned SW = WIDTH + FRAC;
  localparam int unsigned VW = WIDTH + 2 * FRAC;
  localparam logic [FRAC:0] One = {1'b1, {FRAC{1'b0}}};
  localparam logic [SW-1:0] HalfLsb = SW'(1) << (FRAC - 1);

  logic [SW-1:0] a_d, b_d, a_q, b_q;
  logic [FRAC:0] fy_q;
  logic [VW-1:0] v;
  logic [SW-1:0] trunc, sample_d, sample_q;

  // Weights sum to One, so every partial sum stays within SW / VW bits.
  always_comb begin
    a_d   = SW'(p00_i) * SW'(One - fx_i) + SW'(p01_i) * SW'(fx_i);
    b_d   = SW'(p10_i) * SW'(One - fx_i) + SW'(p11_i) * SW'(fx_i);
    v     = VW'(a_q) * VW'(One - fy_q) + VW'(b_q) * VW'(fy_q);
    trunc = SW'(v >> FRAC);
`ifdef INTERP_ROUND_EN
    sample_d = ((trunc + HalfLsb) >> FRAC) << FRAC;
`else
    sample_d = trunc;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      fy_q     <= '0;
      sample_q <= '0;
    end else if (en_i) begin
      a_q      <= a_d;
      b_q      <= b_d;
      fy_q     <= fy_i;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/interpolation_ring_seq.sv
// Sequential 8-point ring sampler: one window in, eight interpolated samples out (k = 0..7).
// Output rounding is selected by INTERP_ROUND_EN inside interp_lerp_pipe.
module interpolation_ring_seq
  import mrelbp_interp_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned RADIUS = 8,
  parameter int unsigned FRAC   = 8,
  localparam int unsigned WIN   = 2 * RADIUS + 1,
  localparam int unsigned SW    = WIDTH + FRAC
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [WIN*WIN*WIDTH-1:0]   i_window,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [SW-1:0]              o_sample,
  output logic [2:0]                 o_index,
  output logic                       o_last
);

  localparam point_t Pts [NPOINTS] = '{
    ring_point(0, RADIUS, FRAC), ring_point(1, RADIUS, FRAC),
    ring_point(2, RADIUS, FRAC), ring_point(3, RADIUS, FRAC),
    ring_point(4, RADIUS, FRAC), ring_point(5, RADIUS, FRAC),
    ring_point(6, RADIUS, FRAC), ring_point(7, RADIUS, FRAC)
  };

  function automatic logic [WIDTH-1:0] pix(input logic [WIN*WIN*WIDTH-1:0] w,
                                           input logic [7:0] r, input logic [7:0] c);
    int unsigned idx;
    idx = (32'(r) * WIN + 32'(c)) * WIDTH;
    return w[idx +: WIDTH];
  endfunction

  ring_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        init_q;
  logic [WIN*WIN*WIDTH-1:0] win_q;
  logic        accept, issue, en, last_hs;

  logic [7:0]       row0, col0, row1, col1;
  logic [WIDTH-1:0] p00_d, p01_d, p10_d, p11_d, p00_q, p01_q, p10_q, p11_q;
  logic [FRAC:0]    fx_d, fy_d, fx_q, fy_q;
  logic             s0_valid_q, s1_valid_q, out_valid_q, out_last_q;
  logic [2:0]       s0_idx_q, s1_idx_q, out_idx_q;

  // A stalled output freezes the whole pipe, including the issue counter.
  assign en      = !(out_valid_q && !i_ready);
  assign accept  = i_valid && o_ready;
  assign last_hs = out_valid_q && i_ready && out_last_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: if (en && cnt_q == 3'd7) state_d = StDrain;
      StDrain: if (last_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // init_q holds o_ready low until the first edge after reset release.
  always_comb begin
    o_ready = init_q && (state_q == StIdle);
    issue   = (state_q == StIssue);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept)           cnt_d = 3'd0;
    else if (issue && en) cnt_d = cnt_q + 3'd1;
  end

  // Corner select; the +1 neighbour is clamped at the window edge where its weight is zero.
  always_comb begin
    row0  = Pts[cnt_q].row;
    col0  = Pts[cnt_q].col;
    row1  = (row0 == 8'(WIN - 1)) ? row0 : row0 + 8'd1;
    col1  = (col0 == 8'(WIN - 1)) ? col0 : col0 + 8'd1;
    p00_d = pix(win_q, row0, col0);
    p01_d = pix(win_q, row0, col1);
    p10_d = pix(win_q, row1, col0);
    p11_d = pix(win_q, row1, col1);
    fx_d  = Pts[cnt_q].fx[FRAC:0];
    fy_d  = Pts[cnt_q].fy[FRAC:0];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      init_q      <= 1'b0;
      cnt_q       <= '0;
      win_q       <= '0;
      s0_valid_q  <= 1'b0;
      s0_idx_q    <= '0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      init_q <= 1'b1;
      cnt_q  <= cnt_d;
      if (accept) win_q <= i_window;
      if (en) begin
        s0_valid_q  <= issue;
        s0_idx_q    <= cnt_q;
        p00_q       <= p00_d;
        p01_q       <= p01_d;
        p10_q       <= p10_d;
        p11_q       <= p11_d;
        fx_q        <= fx_d;
        fy_q        <= fy_d;
        s1_valid_q  <= s0_valid_q;
        s1_idx_q    <= s0_idx_q;
        out_valid_q <= s1_valid_q;
        out_idx_q   <= s1_idx_q;
        out_last_q  <= s1_valid_q && (s1_idx_q == 3'd7);
      end
    end
  end

  interp_lerp_pipe #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_lerp (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .en_i     (en),
    .p00_i    (p00_q),
    .p01_i    (p01_q),
    .p10_i    (p10_q),
    .p11_i    (p11_q),
    .fx_i     (fx_q),
    .fy_i     (fy_q),
    .sample_o (o_sample)
  );

  assign o_valid = out_valid_q;
  assign o_index = out_idx_q;
  assign o_last  = out_last_q;

endmodule

// File: tb/tb_interpolation_ring_seq.sv
// Directed bench for interpolation_ring_seq with RADIUS = 8; honours INTERP_ROUND_EN.
module tb_interpolation_ring_seq;

  localparam int unsigned WIN = 17;
  localparam int unsigned SW  = 16;

`ifdef INTERP_ROUND_EN
  localparam logic [15:0] Hi = 16'd35072;
  localparam logic [15:0] Lo = 16'd5888;
`else
  localparam logic [15:0] Hi = 16'd34960;
  localparam logic [15:0] Lo = 16'd6000;
`endif

  logic                   clk = 1'b0;
  logic                   i_rst, i_valid, i_ready;
  logic [WIN*WIN*8-1:0]   win;
  logic                   o_ready, o_valid, o_last;
  logic [SW-1:0]          o_sample;
  logic [2:0]             o_index;
  logic [15:0]            exp_s [8];
  int                     checks = 0;
  int                     errors = 0;
  int                     first, stray;

  always #5 clk = ~clk;

  interpolation_ring_seq #(
    .WIDTH  (8),
    .RADIUS (8),
    .FRAC   (8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_window (win),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sample (o_sample),
    .o_index  (o_index),
    .o_last   (o_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // mode 0: all 100, mode 1: 10*col, mode 2: 10*row
  task automatic set_win(input int mode);
    for (int r = 0; r < WIN; r++)
      for (int c = 0; c < WIN; c++)
        win[(r*WIN+c)*8 +: 8] = (mode == 0) ? 8'd100 : (mode == 1) ? 8'(10*c) : 8'(10*r);
  endtask

  task automatic set_exp(input int mode);
    if (mode == 0) begin
      for (int k = 0; k < 8; k++) exp_s[k] = 16'd25600;
    end else if (mode == 1) begin
      exp_s = '{16'd40960, Hi, 16'd20480, Lo, 16'd0, Lo, 16'd20480, Hi};
    end else begin
      exp_s = '{16'd20480, Hi, 16'd40960, Hi, 16'd20480, Lo, 16'd0, Lo};
    end
  endtask

  // Call at a negedge with o_ready high; returns after the accept edge.
  task automatic start_frame();
    chk("ready_before_accept", o_ready, 1);
    i_valid = 1'b1;
    @(negedge clk);
    chk("ready_after_accept", o_ready, 0);
    i_valid = 1'b0;
  endtask

  // Takes n samples in order; optionally holds i_ready low for stall_n cycles at k = stall_at.
  task automatic collect(input int n, input int stall_at, input int stall_n, output int first_v);
    int got, guard, left;
    got = 0; guard = 0; left = stall_n; first_v = -1;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      chk("ready_low_in_frame", o_ready, 0);
      if (o_valid) begin
        if (first_v < 0) first_v = guard;
        chk("index", o_index, got);
        chk("sample", o_sample, exp_s[got]);
        chk("last", o_last, (got == 7));
        if (left > 0 && got == stall_at) begin
          i_ready = 1'b0;
          left--;
        end else begin
          i_ready = 1'b1;
          got++;
        end
      end else begin
        i_ready = 1'b1;
      end
    end
    chk("sample_count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    set_win(0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_sample", o_sample, 0);
    chk("rst_index", o_index, 0);
    chk("rst_last", o_last, 0);
    i_rst = 1'b0;
    #1 chk("ready_before_first_edge", o_ready, 0);
    @(negedge clk);
    chk("ready_after_release", o_ready, 1);

    // Flat window: every point is 100 << 8; first valid three edges after accept.
    set_exp(0);
    start_frame();
    collect(8, -1, 0, first);
    chk("latency_flat", first, 3);
    @(negedge clk);
    chk("ready_back_flat", o_ready, 1);
    chk("valid_idle_flat", o_valid, 0);

    // Column ramp exercises fx on diagonals.
    set_win(1); set_exp(1);
    start_frame();
    collect(8, -1, 0, first);
    chk("latency_col", first, 3);
    @(negedge clk);
    chk("ready_back_col", o_ready, 1);

    // Same window with a 3-cycle stall on k = 2.
    start_frame();
    collect(8, 2, 3, first);
    @(negedge clk);
    chk("ready_back_stall", o_ready, 1);

    // Back-to-back: i_valid held; frame 2 (row ramp, exercises fy) accepted right after k = 7.
    i_valid = 1'b1;
    @(negedge clk);
    chk("b2b_accept1", o_ready, 0);
    set_win(2);
    collect(8, -1, 0, first);
    chk("b2b_latency1", first, 3);
    @(negedge clk);
    chk("b2b_ready_gap", o_ready, 1);
    set_exp(2);
    @(negedge clk);
    chk("b2b_accept2", o_ready, 0);
    i_valid = 1'b0;
    collect(8, -1, 0, first);
    chk("b2b_latency2", first, 3);
    @(negedge clk);
    chk("ready_back_b2b", o_ready, 1);

    // Reset after three samples: asynchronous clear, no stray samples afterwards.
    set_win(0); set_exp(0);
    start_frame();
    collect(3, -1, 0, first);
    @(negedge clk);
    chk("mid_valid_before_rst", o_valid, 1);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_ready", o_ready, 0);
    chk("mid_rst_sample", o_sample, 0);
    @(negedge clk);
    i_rst = 1'b0;
    #1 chk("mid_ready_before_edge", o_ready, 0);
    @(negedge clk);
    chk("mid_ready_after_release", o_ready, 1);
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_valid) stray++;
    end
    chk("mid_stray_samples", stray, 0);
    chk("mid_ready_idle", o_ready, 1);

    // Fresh frame after reset still works.
    set_win(1); set_exp(1);
    start_frame();
    collect(8, -1, 0, first);
    chk("latency_post_rst", first, 3);
    @(negedge clk);
    chk("ready_back_post_rst", o_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interpolation_ring_seq.md
# interpolation_ring_seq

Sequential, parametrised ring sampler for the MRELBP feature path. It accepts one square pixel window through a valid/ready handshake and produces the eight neighbour samples on a circle of configurable radius as a stream. Samples leave in order k = 0..7 (45° steps). Diagonal points go through a single shared two-stage bilinear pipeline, with backpressure honoured throughout. It sits between the window buffer and the MRELBP comparator/encoder, and supersedes the fixed-radius combinational 8-point interpolator.

## Interface
- WIDTH, 8: pixel width.
- RADIUS, 8: ring radius in pixels, legal 1..16. Window side WIN = 2*RADIUS+1.
- FRAC, 8: fractional bits of weights and samples. Sample width SW = WIDTH+FRAC.
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  window valid.
- o_ready  out  1  block can accept a window.
- i_window  in  WIN*WIN*WIDTH  pixel (r,c) at bits [(r*WIN+c)*WIDTH +: WIDTH]; row r grows downward.
- o_valid  out  1  sample valid.
- i_ready  in  1  downstream accepts the sample.
- o_sample  out  SW  interpolated sample, unsigned Q(WIDTH).(FRAC).
- o_index  out  3  point index k.
- o_last  out  1  high with k = 7.

## Operation
- FSM states:
  - IDLE: o_ready = 1. On i_valid, the window is captured and the FSM goes to ISSUE.
  - ISSUE: issues k = 0..7, one per unstalled cycle. After issuing k = 7 it goes to DRAIN.
  - DRAIN: returns to IDLE when the k = 7 sample handshakes (o_valid && i_ready).
- Geometry, with centre (RADIUS, RADIUS):
  - Axis points:
    - k = 0: (R, 2R).
    - k = 2: (2R, R).
    - k = 4: (R, 0).
    - k = 6: (0, R).
    - Each uses fx = fy = 0.
  - Diagonal points:
    - d = RADIUS*COS45_Q8, where COS45_Q8 = 181, computed at elaboration.
    - di = d >> 8; df = d[7:0], scaled to FRAC.
  - Positive direction: base = R+di, frac = df.
  - Negative direction: base = R-di-1, frac = 2^FRAC - df (for df = 0, base = R-di with frac 0).
  - Point k = 1 is (+row, +col), k = 3 is (+row, −col), k = 5 is (−row, −col), k = 7 is (−row, +col).
  - Corners: p00 = (br, bc), p01 = (br, bc+1), p10 = (br+1, bc), p11 = (br+1, bc+1).
- Arithmetic:
  - Stage 1: a = p00*(2^FRAC−fx) + p01*fx, and b = p10*(2^FRAC−fx) + p11*fx. Both are SW bits (max 255*256). Weight terms are FRAC+1 bits.
  - Stage 2: v = a*(2^FRAC−fy) + b*fy, which is WIDTH+2*FRAC bits. o_sample = v >> FRAC (truncate).
  - Axis points are therefore exactly pixel << FRAC.
- Stall: when o_valid && !i_ready, the issue counter, both stages and the output register all hold. o_sample, o_index and o_last stay stable.
- Only one window is in flight at a time. A new window can be accepted no earlier than the cycle after the k = 7 handshake.
- Reset mid-frame: FSM returns to IDLE, all valids clear, and the partial frame is discarded with no further samples.

## Timing
- Reset values: o_ready = 0, o_valid = 0, o_sample = 0, o_index = 0, o_last = 0.
  - o_ready rises on the first i_clk edge after i_rst deasserts.
- Accept at edge E0 (i_valid && o_ready). o_ready is low from E0 until DRAIN completes.
- With no stalls:
  - k = 0 is valid after E3.
  - k = 0..7 appear on 8 consecutive cycles.
  - o_last is high on the eighth sample.
  - o_ready is high again after the edge that completes the k = 7 handshake.
- Latency per point is 3 cycles: issue/corner select, stage 1, stage 2/output register.
- i_valid while o_ready = 0 is ignored. The source must hold the window.

## Configuration
- INTERP_ROUND_EN defined: o_sample = ((v >> FRAC) + 2^(FRAC−1)) >> FRAC << FRAC. That is, round-half-up to integer pixel with the low FRAC bits zero. This cannot overflow because v ≤ 255·2^2FRAC.
- Undefined: full-precision truncated fixed-point output.
- Port widths and timing are identical in both cases.

## Structure
- Package mrelbp_interp_pkg holds:
  - NPOINTS = 8 and COS45_Q8 = 181.
  - typedef struct point_t {row, col, fx, fy}.
  - function ring_point(k, radius, frac) returning point_t, used for the elaboration-time coordinate table.
  - FSM state enum.
- Sub-module interp_lerp_pipe: the two-stage bilinear datapath with a shared enable (stall) input, parametrised by WIDTH and FRAC.

## Test plan
- RADIUS = 8, all pixels 100 → eight samples of 25600, o_index 0..7, o_last only on k = 7, first o_valid 3 cycles after accept.
- RADIUS = 8, pixel(r,c) = 10*c → k0 = 40960, k1 = 34960, k2 = 20480, k3 = 6000, k4 = 0, k5 = 6000, k6 = 20480, k7 = 34960.
- Same window with i_ready low for 3 cycles during k = 2 → o_sample/o_index held, all 8 samples delivered in order with none lost or duplicated.
- i_valid held high with two windows → second accepted exactly one cycle after the k = 7 handshake; o_ready low for the whole of frame 1.
- i_rst pulsed after 3 samples → o_valid drops asynchronously, o_ready returns 1 one edge after release, no stray samples.
- INTERP_ROUND_EN, second window → k1 = 35072 and k3 = 5888; without the macro, 34960 and 6000.
